// File: rtl/plot_arbiter_pkg.sv
// plot_arbiter_pkg
//   Shared widths and FSM encoding for the pixel-plot arbiter and its
//   clear sweeper.
//   X_W     : horizontal coordinate width (9 bits, up to 511)
//   Y_W     : vertical coordinate width (8 bits, up to 255)
//   COLOR_W : pixel colour width (3 bits, RGB)
package plot_arbiter_pkg;

  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int COLOR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/plot_arbiter_clear.sv
// clear_sweeper
//   Raster walker for a full-screen clear. A start pulse (accepted only
//   while not already sweeping) begins at (0,0) and presents one pixel
//   per cycle, x inner and y outer, ending at (SCREEN_W-1, SCREEN_H-1).
//   Ports:
//     CLOCK_50 : clock, rising edge
//     reset    : asynchronous, active-high; abandons any sweep
//     start    : begin a sweep (ignored while running)
//     x, y     : current sweep coordinate
//     valid    : x/y hold a pixel to be plotted this cycle
//     done     : valid pixel is the final one of the frame
module clear_sweeper
  import plot_arbiter_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           start,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           valid,
  output logic           done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  logic running;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else if (!running) begin
      if (start) begin
        running <= 1'b1;
        x       <= '0;
        y       <= '0;
      end
    end else if (x == X_LAST) begin
      x <= '0;
      if (y == Y_LAST) begin
        // Frame finished: park counters at zero so nothing runs past the frame.
        running <= 1'b0;
        y       <= '0;
      end else begin
        y <= y + 1'b1;
      end
    end else begin
      x <= x + 1'b1;
    end
  end

  assign valid = running;
  assign done  = running && (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter
//   Shares the VGA adapter's pixel-write port between two requesters
//   (A: HTML renderer, B: cursor/overlay) with round-robin arbitration, and
//   performs a full-screen clear on request.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no requester pending; grants still allowed
//   SERVE  | at least one requester pending; one grant per cycle
//   CLEAR  | clear sweep running; no grants, clear_req ignored
//
//   Ports:
//     CLOCK_50, reset            : clock / async active-high reset
//     clear_req, clear_busy      : start a clear / clear in progress
//     a_req,a_x,a_y,a_colour,a_ack : requester A handshake and pixel
//     b_req,b_x,b_y,b_colour,b_ack : requester B handshake and pixel
//     vga_x,vga_y,vga_colour,vga_plot : registered pixel write
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int                 SCREEN_W     = 320,
  parameter int                 SCREEN_H     = 240,
  parameter logic [COLOR_W-1:0] CLEAR_COLOUR = {COLOR_W{1'b1}}
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               clear_req,
  output logic               clear_busy,
  input  logic               a_req,
  input  logic [X_W-1:0]     a_x,
  input  logic [Y_W-1:0]     a_y,
  input  logic [COLOR_W-1:0] a_colour,
  output logic               a_ack,
  input  logic               b_req,
  input  logic [X_W-1:0]     b_x,
  input  logic [Y_W-1:0]     b_y,
  input  logic [COLOR_W-1:0] b_colour,
  output logic               b_ack,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               vga_plot
);

  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);

  state_t state, state_nxt;

  logic           last_b;       // last grant went to B
  logic           grant_a, grant_b;
  logic           sweep_start;
  logic [X_W-1:0] sweep_x;
  logic [Y_W-1:0] sweep_y;
  logic           sweep_valid, sweep_done;
  logic           a_in_frame, b_in_frame;

  assign a_in_frame = (a_x < X_LIM) && (a_y < Y_LIM);
  assign b_in_frame = (b_x < X_LIM) && (b_y < Y_LIM);

  clear_sweeper #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_sweep (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (sweep_start),
    .x        (sweep_x),
    .y        (sweep_y),
    .valid    (sweep_valid),
    .done     (sweep_done)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_SERVE: begin
        if (clear_req)             state_nxt = ST_CLEAR;
        else if (a_req || b_req)   state_nxt = ST_SERVE;
        else                       state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        if (sweep_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant is combinational so a lone requester can be acked every cycle;
  // only the ack depends on req directly, the vga_* path is registered.
  // Reset gates the acks so they drop the instant reset asserts.
  always_comb begin
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    sweep_start = 1'b0;
    if (!reset && (state != ST_CLEAR)) begin
      if (clear_req) begin
        sweep_start = 1'b1;
      end else if (a_req && b_req) begin
        grant_a = last_b;
        grant_b = !last_b;
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
    a_ack = grant_a;
    b_ack = grant_b;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      last_b     <= 1'b1;
      clear_busy <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      clear_busy <= (state_nxt == ST_CLEAR);
      vga_plot   <= 1'b0;
      if (state == ST_CLEAR) begin
        if (sweep_valid) begin
          vga_x      <= sweep_x;
          vga_y      <= sweep_y;
          vga_colour <= CLEAR_COLOUR;
          vga_plot   <= 1'b1;
        end
      end else if (grant_a) begin
        last_b <= 1'b0;
        // Off-screen pixels are acked so the requester can move on,
        // but never reach the adapter.
        if (a_in_frame) begin
          vga_x      <= a_x;
          vga_y      <= a_y;
          vga_colour <= a_colour;
          vga_plot   <= 1'b1;
        end
      end else if (grant_b) begin
        last_b <= 1'b1;
        if (b_in_frame) begin
          vga_x      <= b_x;
          vga_y      <= b_y;
          vga_colour <= b_colour;
          vga_plot   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
module tb_plot_arbiter;

  localparam int W     = 320;
  localparam int H     = 60;
  localparam int TOTAL = W * H;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       clear_req = 1'b0;
  logic       clear_busy;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [8:0] a_x = '0, b_x = '0;
  logic [7:0] a_y = '0, b_y = '0;
  logic [2:0] a_colour = '0, b_colour = '0;
  logic       a_ack, b_ack;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  plot_arbiter #(.SCREEN_W(W), .SCREEN_H(H), .CLEAR_COLOUR(3'b111)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .a_req      (a_req),
    .a_x        (a_x),
    .a_y        (a_y),
    .a_colour   (a_colour),
    .a_ack      (a_ack),
    .b_req      (b_req),
    .b_x        (b_x),
    .b_y        (b_y),
    .b_colour   (b_colour),
    .b_ack      (b_ack),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {int x; int y; int c;} pix_t;
  pix_t a_q[$];
  pix_t b_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // reference model state: what the adapter port should show, plus clear progress
  bit m_busy, m_clr, m_plot, m_last_b;
  int m_x, m_y, m_col, m_n;
  bit exp_a, exp_b;

  bit log_en = 1'b0;
  int grant_log = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_clr = 0; m_plot = 0; m_last_b = 1;
    m_x = 0; m_y = 0; m_col = 0; m_n = 0;
  endtask

  task automatic drive();
    a_req = (a_q.size() > 0);
    if (a_req) begin
      a_x = 9'(a_q[0].x); a_y = 8'(a_q[0].y); a_colour = 3'(a_q[0].c);
    end
    b_req = (b_q.size() > 0);
    if (b_req) begin
      b_x = 9'(b_q[0].x); b_y = 8'(b_q[0].y); b_colour = 3'(b_q[0].c);
    end
  endtask

  function automatic pix_t rand_pix();
    pix_t p;
    p.x = int'($urandom_range(0, 339));
    p.y = int'($urandom_range(0, 69));
    p.c = int'($urandom_range(0, 7));
    return p;
  endfunction

  function automatic pix_t mk(input int x, input int y, input int c);
    pix_t p;
    p.x = x; p.y = y; p.c = c;
    return p;
  endfunction

  // One clock: check at the falling edge, advance the model across the
  // rising edge, then present new requester inputs just after it.
  task automatic cycle();
    pix_t p;
    @(negedge CLOCK_50);
    exp_a = 0; exp_b = 0;
    if (!reset && !m_clr && !clear_req) begin
      if (a_req && b_req) begin
        exp_a = m_last_b; exp_b = !m_last_b;
      end else begin
        exp_a = a_req; exp_b = b_req;
      end
    end
    check_val("a_ack", int'(a_ack), int'(exp_a));
    check_val("b_ack", int'(b_ack), int'(exp_b));
    check_val("clear_busy", int'(clear_busy), int'(m_busy));
    check_val("vga_plot", int'(vga_plot), int'(m_plot));
    check_val("vga_x", int'(vga_x), m_x);
    check_val("vga_y", int'(vga_y), m_y);
    check_val("vga_colour", int'(vga_colour), m_col);
    if (log_en) begin
      if (a_ack) grant_log = grant_log * 10 + 1;
      if (b_ack) grant_log = grant_log * 10 + 2;
    end
    if (reset) begin
      model_reset();
    end else if (m_clr) begin
      m_x = m_n % W; m_y = m_n / W; m_col = 7; m_plot = 1;
      m_n++;
      if (m_n == TOTAL) begin m_clr = 0; m_busy = 0; end
    end else if (clear_req) begin
      m_clr = 1; m_busy = 1; m_n = 0; m_plot = 0;
    end else if (exp_a || exp_b) begin
      p = exp_a ? a_q[0] : b_q[0];
      m_last_b = exp_b;
      if (p.x < W && p.y < H) begin
        m_x = p.x; m_y = p.y; m_col = p.c; m_plot = 1;
      end else begin
        m_plot = 0;
      end
      if (exp_a) void'(a_q.pop_front());
      else       void'(b_q.pop_front());
    end else begin
      m_plot = 0;
    end
    @(posedge CLOCK_50);
    #1;
    drive();
  endtask

  initial begin
    int k, cnt;
    model_reset();
    // reset with A requesting: acks must stay low
    a_q.push_back(mk(7, 7, 5));
    drive();
    cycle();
    cycle();
    a_q.delete();
    drive();
    reset = 1'b0;

    // tie after reset: A first, then alternate
    log_en = 1; grant_log = 0;
    a_q.push_back(mk(1, 2, 1)); a_q.push_back(mk(3, 4, 2));
    b_q.push_back(mk(5, 6, 3)); b_q.push_back(mk(7, 8, 4));
    drive();
    for (int i = 0; i < 6; i++) cycle();
    check_val("rr_order", grant_log, 1212);

    // A alone, back-to-back
    grant_log = 0;
    a_q.push_back(mk(10, 20, 4)); a_q.push_back(mk(11, 20, 4)); a_q.push_back(mk(12, 20, 4));
    drive();
    for (int i = 0; i < 3; i++) cycle();
    check_val("a_b2b_acks", grant_log, 111);
    cycle();
    cycle();

    // off-screen pixels acked but not plotted
    grant_log = 0;
    a_q.push_back(mk(320, 5, 3)); a_q.push_back(mk(5, 60, 2));
    drive();
    for (int i = 0; i < 4; i++) cycle();
    check_val("offscreen_acks", grant_log, 11);
    log_en = 0;

    // random traffic from both requesters
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && a_q.size() < 3) a_q.push_back(rand_pix());
      if ($urandom_range(0, 3) == 0 && b_q.size() < 3) b_q.push_back(rand_pix());
      drive();
      cycle();
    end
    for (int i = 0; i < 20 && (a_q.size() + b_q.size()) > 0; i++) cycle();
    check_val("drain", a_q.size() + b_q.size(), 0);
    cycle();

    // full clear; A request and a second clear_req arrive mid-sweep
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    check_val("busy_rise", int'(clear_busy), 1);
    log_en = 1; grant_log = 0;
    k = 0; cnt = 0;
    while (k < TOTAL + 20) begin
      if (k == 5000) begin
        a_q.push_back(mk(33, 44, 6));
        drive();
        clear_req = 1'b1;
      end
      cycle();
      clear_req = 1'b0;
      k++;
      if (vga_plot) cnt++;
      if (k == 1) begin
        check_val("first_x", int'(vga_x), 0);
        check_val("first_y", int'(vga_y), 0);
      end
      if (k == W) begin
        check_val("row0_end_x", int'(vga_x), W - 1);
        check_val("row0_end_y", int'(vga_y), 0);
      end
      if (k == W + 1) begin
        check_val("row1_start_x", int'(vga_x), 0);
        check_val("row1_start_y", int'(vga_y), 1);
      end
      if (!clear_busy) break;
    end
    check_val("clear_plot_count", cnt, TOTAL);
    check_val("last_x", int'(vga_x), W - 1);
    check_val("last_y", int'(vga_y), H - 1);
    check_val("last_colour", int'(vga_colour), 7);
    cycle();
    check_val("ack_after_clear", grant_log, 1);
    log_en = 0;
    for (int i = 0; i < 5; i++) cycle();
    check_val("no_restart", int'(clear_busy), 0);

    // reset in the middle of a sweep at pixel (100,50)
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    k = 0;
    while (m_n < 50 * W + 101 && k < TOTAL) begin
      cycle();
      k++;
    end
    check_val("mid_x", int'(vga_x), 100);
    check_val("mid_y", int'(vga_y), 50);
    #2;
    reset = 1'b1;
    a_q.push_back(mk(9, 9, 1));
    drive();
    #1;
    check_val("rst_plot", int'(vga_plot), 0);
    check_val("rst_busy", int'(clear_busy), 0);
    check_val("rst_a_ack", int'(a_ack), 0);
    check_val("rst_b_ack", int'(b_ack), 0);
    check_val("rst_vga_x", int'(vga_x), 0);
    a_q.delete();
    drive();
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (vga_plot || clear_busy) cnt++;
    end
    check_val("idle_after_reset", cnt, 0);

    a_q.push_back(mk(100, 10, 2));
    drive();
    for (int i = 0; i < 3; i++) cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter SCREEN_W, default 320, pixels per row.
REQ-002 Parameter SCREEN_H, default 240, rows per frame.
REQ-003 Parameter CLEAR_COLOUR, default 3'b111 (white), fill colour for screen clear.
REQ-004 The clock port SHALL be CLOCK_50, input, 1 bit; it is the single clock, and everything is rising-edge.
REQ-005 The reset port SHALL be reset, input, 1 bit; it is asynchronous and active-high.
REQ-006 clear_req  input  1  single-cycle request to fill the whole screen with CLEAR_COLOUR.
REQ-007 clear_busy  output  1  high while the clear sweep runs.
REQ-008 a_req  input  1  requester A (HTML renderer) has a pixel pending.
REQ-009 a_x / a_y / a_colour  input  9 / 8 / 3  requester A pixel.
REQ-010 a_ack  output  1  one-cycle pulse: A's pixel accepted.
REQ-011 b_req, b_x, b_y, b_colour, b_ack  same widths and meaning as A, for requester B (cursor/overlay).
REQ-012 vga_x / vga_y / vga_colour / vga_plot  output  9 / 8 / 3 / 1  registered pixel write to the VGA adapter.

Function
REQ-013 The FSM SHALL have three states: IDLE, SERVE, CLEAR.
- Transitions: IDLE->SERVE on any req; SERVE->IDLE when no req; IDLE/SERVE->CLEAR on clear_req.
- clear_req has priority over pending requests in the same cycle.
REQ-014 In IDLE/SERVE, at most one requester SHALL be granted per cycle.
- Granted requester gets ack=1 in that cycle.
- Its x/y/colour appear on vga_* with vga_plot=1 exactly one cycle later.
REQ-015 Arbitration SHALL be round-robin on a last-granted pointer.
- Both requesting: grant the one not granted last.
- Single requester: always granted.
- Pointer resets to B, so A wins the first tie.
REQ-016 A requester SHALL hold req and data stable until ack.
- After ack it may drop req or present the next pixel immediately, giving back-to-back acks when alone.
REQ-017 A pixel with x >= SCREEN_W or y >= SCREEN_H SHALL be acked but dropped (vga_plot stays 0 that cycle).
REQ-018 CLEAR SHALL sweep x 0..SCREEN_W-1 (inner) and y 0..SCREEN_H-1 (outer) at one pixel per cycle.
- vga_plot=1 and vga_colour=CLEAR_COLOUR throughout; 76800 plots for default parameters.
- The first pixel (0,0) appears on vga_* the cycle after entering CLEAR.
REQ-019 clear_busy SHALL rise the cycle after clear_req is sampled.
- It falls the cycle after the last pixel (SCREEN_W-1, SCREEN_H-1) is issued.
- The FSM then returns to IDLE.
REQ-020 During CLEAR: no ack is issued, and clear_req is ignored (no restart).
- Pending requests wait and are arbitrated normally after CLEAR ends.
REQ-021 x wrap: at x=SCREEN_W-1, x returns to 0 and y increments.
- Counter widths: 9 bits for x, 8 bits for y; no overflow beyond the frame.
REQ-022 vga_plot SHALL be 0 in any cycle with no grant and no clear pixel.
- vga_x/vga_y/vga_colour hold their last value when vga_plot is 0.

Reset
REQ-023 Asserting reset at any time SHALL immediately force:
- state=IDLE; vga_plot=0; vga_x=0, vga_y=0, vga_colour=0;
- a_ack=b_ack=0; clear_busy=0; counters=0; RR pointer=B.
REQ-024 Reset during CLEAR SHALL abandon the sweep.
- After release, no clear resumes without a new clear_req.

Structure
REQ-025 Widths X=9, Y=8, COLOUR=3, and the state encodings, SHALL live in the shared project defines header as the X/Y/COLOR width macros; no literal widths in the module body.
REQ-026 The clear sweep SHALL be a sub-module, clear_sweeper, with ports:
- inputs: CLOCK_50, reset, start;
- outputs: x, y, valid, done.
REQ-027 All outputs SHALL be registered; no combinational path from req inputs to vga_*.

Verification
REQ-028 A alone, a_req held 3 cycles with (10,20,3'b100), (11,20,3'b100), (12,20,3'b100) -> a_ack on 3 consecutive cycles; vga_plot 3 cycles, each one cycle later, matching data.
REQ-029 A and B both held with distinct pixels for 4 grants after reset -> grants A,B,A,B; each vga_* matches the granted pixel.
REQ-030 clear_req pulse from IDLE -> clear_busy rises next cycle; vga_plot high for exactly 76800 cycles; first pixel (0,0), last (319,239), all colour 3'b111; pixel (0,1) follows (319,0).
REQ-031 a_req asserted mid-CLEAR, plus a second clear_req mid-CLEAR -> no a_ack until clear_busy falls; A acked in the first cycle after; sweep not restarted.
REQ-032 a_req with x=320, y=5 -> a_ack=1, vga_plot stays 0.
REQ-033 reset asserted at sweep pixel (100,50) -> vga_plot, clear_busy and all acks 0 immediately; after release, idle with no plots until new stimulus.
